// File: rtl/irq_ctl_if.sv
// Signal bundle between the interrupt controller and its surroundings (sources, mask CSR, core control).
// The master side drives the sources, the mask write and the core handshake. The slave side is irq_ctl.
interface irq_ctl_if #(
  parameter int unsigned NSRC = 8,
  parameter int unsigned CW   = 3
);
  logic [NSRC-1:0] src;
  logic            mask_we;
  logic [NSRC-1:0] mask_wd;
  logic            supervisor;
  logic            take;
  logic            eoi;
  logic            irq;
  logic [CW-1:0]   cause;
  logic            in_service;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;

  modport master (
    output src, mask_we, mask_wd, supervisor, take, eoi,
    input  irq, cause, in_service, pending, mask
  );

  modport slave (
    input  src, mask_we, mask_wd, supervisor, take, eoi,
    output irq, cause, in_service, pending, mask
  );
endinterface

// File: rtl/irq_ctl.sv
// Edge-detecting, maskable, fixed-priority interrupt controller.
// Only one handler runs at a time; it is released by eoi.
module irq_ctl #(
  parameter int unsigned NSRC = 8,
  parameter int unsigned CW   = 3
) (
  input  logic      clk,
  input  logic      reset,
  irq_ctl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] mask_r;
  logic            irq_r;
  logic            in_service_r;
  logic [CW-1:0]   cause_r;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [CW-1:0]   win;
  logic            any_elig;
  logic            grant;

  assign rise     = bus.src & ~src_q;
  assign elig     = pending_r & mask_r;
  assign any_elig = |elig;
  assign grant    = (state == REQ) && bus.take;

  always_comb begin
    win = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (elig[i-1]) win = CW'(i-1);
    end
  end

  // The winner is chosen when take arrives, so a late higher-priority edge still wins.
  always_comb begin
    clr = '0;
    if (grant && any_elig) clr[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= '0;
      pending_r <= '0;
      mask_r    <= '0;
    end else begin
      src_q     <= bus.src;
      // A set in the same cycle as the clear takes precedence.
      pending_r <= (pending_r & ~clr) | rise;
      if (bus.mask_we) mask_r <= bus.mask_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      irq_r        <= 1'b0;
      in_service_r <= 1'b0;
      cause_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig && !bus.supervisor) begin
            state <= REQ;
            irq_r <= 1'b1;
          end
        end
        REQ: begin
          if (bus.take) begin
            state        <= SERVICE;
            irq_r        <= 1'b0;
            in_service_r <= 1'b1;
            cause_r      <= win;
          end else if (!any_elig || bus.supervisor) begin
            state <= IDLE;
            irq_r <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state        <= IDLE;
            in_service_r <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          irq_r        <= 1'b0;
          in_service_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq        = irq_r;
  assign bus.in_service = in_service_r;
  assign bus.cause      = cause_r;
  assign bus.pending    = pending_r;
  assign bus.mask       = mask_r;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: basic flow, priority, masking, supervisor, simultaneity, reset.
module tb_irq_ctl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  irq_ctl_if #(.NSRC(8), .CW(3)) bus ();

  irq_ctl #(.NSRC(8), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_irq"}, 32'(bus.irq), 32'd0);
    chk({tag, "_cause"}, 32'(bus.cause), 32'd0);
    chk({tag, "_insvc"}, 32'(bus.in_service), 32'd0);
    chk({tag, "_pend"}, 32'(bus.pending), 32'd0);
    chk({tag, "_mask"}, 32'(bus.mask), 32'd0);
  endtask

  task automatic wr_mask(input logic [7:0] m);
    bus.mask_we = 1'b1;
    bus.mask_wd = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.src        = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wd    = '0;
    bus.supervisor = 1'b0;
    bus.take       = 1'b0;
    bus.eoi        = 1'b0;
    tick(2);
    reset = 1'b0;
    chk_all_zero("reset");

    // Basic flow
    wr_mask(8'hFF);
    chk("basic_mask", 32'(bus.mask), 32'hFF);
    bus.src = 8'h20;
    tick();
    bus.src = '0;
    chk("basic_pend", 32'(bus.pending), 32'h20);
    chk("basic_irq_early", 32'(bus.irq), 32'd0);
    tick();
    chk("basic_irq", 32'(bus.irq), 32'd1);
    tick(2);
    chk("basic_irq_hold", 32'(bus.irq), 32'd1);
    bus.take = 1'b1;
    tick();
    bus.take = 1'b0;
    chk("basic_take_irq", 32'(bus.irq), 32'd0);
    chk("basic_insvc", 32'(bus.in_service), 32'd1);
    chk("basic_cause", 32'(bus.cause), 32'd5);
    chk("basic_pend_clr", 32'(bus.pending), 32'd0);
    bus.take = 1'b1;                 // take outside REQ is ignored
    tick();
    bus.take = 1'b0;
    chk("basic_take_ign", 32'(bus.in_service), 32'd1);
    tick(4);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    chk("basic_eoi", 32'(bus.in_service), 32'd0);
    chk("basic_cause_hold", 32'(bus.cause), 32'd5);
    chk("basic_idle_irq", 32'(bus.irq), 32'd0);

    // Priority
    bus.src = 8'h44;
    tick();
    bus.src = '0;
    chk("prio_pend", 32'(bus.pending), 32'h44);
    tick();
    chk("prio_irq", 32'(bus.irq), 32'd1);
    bus.take = 1'b1;
    tick();
    bus.take = 1'b0;
    chk("prio_cause", 32'(bus.cause), 32'd2);
    chk("prio_pend_left", 32'(bus.pending), 32'h40);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    chk("prio_eoi_irq0", 32'(bus.irq), 32'd0);
    tick();
    chk("prio_reirq", 32'(bus.irq), 32'd1);
    bus.take = 1'b1;
    tick();
    bus.take = 1'b0;
    chk("prio_cause2", 32'(bus.cause), 32'd6);
    chk("prio_pend2", 32'(bus.pending), 32'd0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;

    // Masking and withdrawal
    wr_mask(8'h00);
    bus.src = 8'h08;
    tick();
    bus.src = '0;
    tick(2);
    chk("mask_pend", 32'(bus.pending), 32'h08);
    chk("mask_noirq", 32'(bus.irq), 32'd0);
    wr_mask(8'h08);
    chk("mask_irq_lat1", 32'(bus.irq), 32'd0);
    tick();
    chk("mask_irq", 32'(bus.irq), 32'd1);
    wr_mask(8'h00);
    tick();
    chk("mask_withdraw", 32'(bus.irq), 32'd0);
    chk("mask_pend_keep", 32'(bus.pending), 32'h08);

    // Supervisor, then take+supervisor together
    bus.supervisor = 1'b1;
    wr_mask(8'hFF);
    tick(3);
    chk("sup_block", 32'(bus.irq), 32'd0);
    bus.supervisor = 1'b0;
    tick();
    chk("sup_release", 32'(bus.irq), 32'd1);
    bus.take       = 1'b1;
    bus.supervisor = 1'b1;
    tick();
    bus.take       = 1'b0;
    bus.supervisor = 1'b0;
    chk("sup_take_wins", 32'(bus.in_service), 32'd1);
    chk("sup_take_cause", 32'(bus.cause), 32'd3);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;

    // New edge on bit 1 in the same cycle take clears bit 1
    bus.src = 8'h02;
    tick();
    bus.src = '0;
    tick();
    chk("sim_irq", 32'(bus.irq), 32'd1);
    bus.take = 1'b1;
    bus.src  = 8'h02;
    tick();
    bus.take = 1'b0;
    chk("sim_cause", 32'(bus.cause), 32'd1);
    chk("sim_pend_set_wins", 32'(bus.pending), 32'h02);

    // Reset in SERVICE, src[4] held through reset
    bus.src = 8'h30;
    tick();
    chk("rst_pre_pend", 32'(bus.pending), 32'h32);
    chk("rst_pre_insvc", 32'(bus.in_service), 32'd1);
    bus.src = 8'h10;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rst_mid");
    tick();
    chk("rst_one_edge", 32'(bus.pending), 32'h10);
    wr_mask(8'hFF);
    tick();
    chk("rst_irq", 32'(bus.irq), 32'd1);
    bus.take = 1'b1;
    tick();
    bus.take = 1'b0;
    chk("rst_cause", 32'(bus.cause), 32'd4);
    chk("rst_pend_clr", 32'(bus.pending), 32'd0);
    tick(3);
    chk("rst_no_reedge", 32'(bus.pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
